mem_write_deadlock_reporter: RTL

- Consumer end of the per-instance deadlock monitors' `block` outputs in the mem_write kernel.
- Aggregates NUM_MON monitor block flags and requires a block to persist for THRESH consecutive cycles before declaring deadlock.
- On declaration, latches which monitors were blocked and raises a sticky flag plus a one-cycle irq toward the host/debug shell.
- Also keeps a saturating count of blocked cycles for profiling.

---
 rtl/mem_write_deadlock_reporter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mem_write_deadlock_reporter.sv
// Collects the deadlock monitors' block flags for the mem_write kernel and declares a deadlock
// once blocking has persisted for THRESH consecutive cycles. It also profiles blocked cycles.
module mem_write_deadlock_reporter #(
  parameter int NUM_MON = 4,
  parameter int IDX_W   = 2,
  parameter int THRESH  = 1024,
  parameter int CNT_W   = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               clear,
  input  logic [NUM_MON-1:0] mon_block,
  output logic               deadlock,
  output logic               deadlock_irq,
  output logic [NUM_MON-1:0] deadlock_mask,
  output logic [IDX_W-1:0]   deadlock_idx,
  output logic [CNT_W-1:0]   stall_cycles
);

  typedef enum logic [1:0] {
    IDLE,
    WATCH,
    DETECTED
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(THRESH - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   persist_cnt_q, persist_cnt_d;
  logic [CNT_W-1:0]   stall_cycles_q, stall_cycles_d;
  logic               deadlock_q, deadlock_d;
  logic               deadlock_irq_q, deadlock_irq_d;
  logic [NUM_MON-1:0] deadlock_mask_q, deadlock_mask_d;
  logic [IDX_W-1:0]   deadlock_idx_q, deadlock_idx_d;
  logic               any_blk;
  logic [IDX_W-1:0]   lowest_idx;

  assign any_blk = |mon_block;

  // Scanning downward leaves the lowest set bit as the final assignment.
  always_comb begin
    lowest_idx = '0;
    for (int i = NUM_MON - 1; i >= 0; i--) begin
      if (mon_block[i]) lowest_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_d         = state_q;
    persist_cnt_d   = persist_cnt_q;
    stall_cycles_d  = stall_cycles_q;
    deadlock_d      = deadlock_q;
    deadlock_irq_d  = 1'b0;
    deadlock_mask_d = deadlock_mask_q;
    deadlock_idx_d  = deadlock_idx_q;

    if (clear) begin
      state_d         = enable ? WATCH : IDLE;
      persist_cnt_d   = '0;
      stall_cycles_d  = '0;
      deadlock_d      = 1'b0;
      deadlock_mask_d = '0;
      deadlock_idx_d  = '0;
    end else begin
      if (enable && any_blk && (stall_cycles_q != {CNT_W{1'b1}})) begin
        stall_cycles_d = stall_cycles_q + 1'b1;
      end

      if (!enable) begin
        state_d       = IDLE;
        persist_cnt_d = '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            state_d       = WATCH;
            persist_cnt_d = '0;
          end
          WATCH: begin
            if (!any_blk) begin
              persist_cnt_d = '0;
            end else if (persist_cnt_q == LAST_CNT) begin
              state_d = DETECTED;
              // A sticky deadlock kept across a disable keeps its first snapshot and stays quiet.
              if (!deadlock_q) begin
                deadlock_d      = 1'b1;
                deadlock_irq_d  = 1'b1;
                deadlock_mask_d = mon_block;
                deadlock_idx_d  = lowest_idx;
              end
            end else begin
              persist_cnt_d = persist_cnt_q + 1'b1;
            end
          end
          DETECTED: begin
            state_d = DETECTED;
          end
          default: begin
            state_d       = IDLE;
            persist_cnt_d = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      persist_cnt_q   <= '0;
      stall_cycles_q  <= '0;
      deadlock_q      <= 1'b0;
      deadlock_irq_q  <= 1'b0;
      deadlock_mask_q <= '0;
      deadlock_idx_q  <= '0;
    end else begin
      state_q         <= state_d;
      persist_cnt_q   <= persist_cnt_d;
      stall_cycles_q  <= stall_cycles_d;
      deadlock_q      <= deadlock_d;
      deadlock_irq_q  <= deadlock_irq_d;
      deadlock_mask_q <= deadlock_mask_d;
      deadlock_idx_q  <= deadlock_idx_d;
    end
  end

  assign deadlock      = deadlock_q;
  assign deadlock_irq  = deadlock_irq_q;
  assign deadlock_mask = deadlock_mask_q;
  assign deadlock_idx  = deadlock_idx_q;
  assign stall_cycles  = stall_cycles_q;

endmodule
